// File: rtl/lb_pkg.sv
// Shared definitions for the multi-line buffer.
// Holds the default geometry (pixel width, line depth, number of chained
// lines), a constant-safe clog2, the default fill-counter width, and a
// helper that gives the bit offset of tap k inside the packed tap bus.
package lb_pkg;

    localparam int DATA_W_DEF    = 16;
    localparam int MAX_ROW_DEF   = 256;
    localparam int NUM_LINES_DEF = 2;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    // Fill must reach NUM_LINES*MAX_ROW, hence the +1.
    localparam int FILL_W = clog2(NUM_LINES_DEF * MAX_ROW_DEF + 1);

    function automatic int tap_base(input int k, input int data_w);
        return k * data_w;
    endfunction

endpackage

// File: rtl/multi_line_buffer_line_ram.sv
// line_ram: one row-delay storage line.
// Single port, combinational read, synchronous write. Because the read is
// combinational, a read and a write to the same address in one cycle
// return the old word (read-before-write).
// Ports:
//   clk      rising-edge clock
//   i_we     write enable
//   i_addr   shared read/write address
//   i_wdata  word written at the edge when i_we=1
//   o_rdata  current contents of i_addr
module line_ram
    import lb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = MAX_ROW_DEF,
    parameter int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    assign o_rdata = r_mem[i_addr];

    // No reset: stale contents are hidden by the valid masking upstream.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

endmodule

// File: rtl/multi_line_buffer.sv
// multi_line_buffer: NUM_LINES chained row delays sharing one circular
// pointer. Tap k presents the pixel from (k+1) rows earlier, masked to zero
// until enough pixels have streamed in to make it real.
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   row_length    row length L, sampled only on fifo_reset (0 = MAX_ROW when
//                 MAX_ROW is a power of two)
//   fifo_reset    synchronous clear of pointer/fill, latches row_length
//   shifting      consume one pixel per cycle while high
//   wr_data_i     input pixel
//   rd_data_o     packed taps, tap k at [(k+1)*DATA_W-1 : k*DATA_W]
//   line_valid_o  per-tap real-data flag
//   cfg_err_o     latched row length is illegal (or none latched yet)
module multi_line_buffer
    import lb_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_ROW   = MAX_ROW_DEF,
    parameter int ADDR_W    = clog2(MAX_ROW),
    parameter int NUM_LINES = NUM_LINES_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ADDR_W-1:0]           row_length,
    input  logic                        fifo_reset,
    input  logic                        shifting,
    input  logic [DATA_W-1:0]           wr_data_i,
    output logic [NUM_LINES*DATA_W-1:0] rd_data_o,
    output logic [NUM_LINES-1:0]        line_valid_o,
    output logic                        cfg_err_o
);

    localparam int   FILL_BITS   = clog2(NUM_LINES * MAX_ROW + 1);
    localparam logic ZERO_IS_MAX = (MAX_ROW == (1 << ADDR_W));

    logic [ADDR_W-1:0]                   r_ptr;
    logic [FILL_BITS-1:0]                r_fill;
    logic [ADDR_W-1:0]                   r_row_len;
    logic                                r_loaded;
    logic [NUM_LINES-1:0][DATA_W-1:0]    r_tap;
    logic [NUM_LINES-1:0]                r_valid;

    logic [NUM_LINES-1:0][DATA_W-1:0]    w_rd;
    logic [NUM_LINES-1:0][DATA_W-1:0]    w_wr;
    logic [FILL_BITS-1:0]                w_len_eff;
    logic [FILL_BITS-1:0]                w_fill_max;
    logic [ADDR_W-1:0]                   w_last;
    logic                                w_len_bad;
    logic                                w_cfg_err;
    logic                                w_shift;
    logic [NUM_LINES-1:0]                w_tap_ok;

    always_comb begin
        w_len_eff  = (r_row_len == '0) ? FILL_BITS'(MAX_ROW) : FILL_BITS'(r_row_len);
        w_fill_max = w_len_eff * FILL_BITS'(NUM_LINES);
        // Modulo arithmetic makes code 0 give MAX_ROW-1 when 0 means MAX_ROW.
        w_last     = r_row_len - ADDR_W'(1);
        w_len_bad  = (r_row_len == '0) ? !ZERO_IS_MAX : (int'(r_row_len) > MAX_ROW);
        // Reset leaves row_len_q=0, which can be legal; r_loaded keeps the
        // error up until a fifo_reset has actually latched a length.
        w_cfg_err  = !r_loaded || w_len_bad;
        w_shift    = shifting && !fifo_reset && !w_cfg_err;
        w_tap_ok   = '0;
        for (int k = 0; k < NUM_LINES; k++) begin
            w_tap_ok[k] = (r_fill >= w_len_eff * FILL_BITS'(k + 1));
        end
    end

    for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
        if (g == 0) begin : g_head
            assign w_wr[g] = wr_data_i;
        end else begin : g_chain
            assign w_wr[g] = w_rd[g-1];
        end

        line_ram #(
            .DATA_W (DATA_W),
            .DEPTH  (MAX_ROW),
            .ADDR_W (ADDR_W)
        ) u_line_ram (
            .clk     (clk),
            .i_we    (w_shift),
            .i_addr  (r_ptr),
            .i_wdata (w_wr[g]),
            .o_rdata (w_rd[g])
        );

        assign rd_data_o[tap_base(g, DATA_W) +: DATA_W] = r_tap[g];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr     <= '0;
            r_fill    <= '0;
            r_row_len <= '0;
            r_loaded  <= 1'b0;
            r_tap     <= '0;
            r_valid   <= '0;
        end else if (fifo_reset) begin
            r_row_len <= row_length;
            r_loaded  <= 1'b1;
            r_ptr     <= '0;
            r_fill    <= '0;
            r_tap     <= '0;
            r_valid   <= '0;
        end else if (w_shift) begin
            r_ptr  <= (r_ptr == w_last) ? '0 : r_ptr + ADDR_W'(1);
            r_fill <= (r_fill >= w_fill_max) ? r_fill : r_fill + FILL_BITS'(1);
            for (int k = 0; k < NUM_LINES; k++) begin
                r_tap[k] <= w_tap_ok[k] ? w_rd[k] : '0;
            end
            r_valid <= w_tap_ok;
        end
    end

    assign line_valid_o = r_valid;
    assign cfg_err_o    = w_cfg_err;

endmodule

// File: tb/tb_multi_line_buffer.sv
// Directed bench for multi_line_buffer. Instance dut_a uses the default
// geometry (MAX_ROW=256); dut_b shares all inputs but has MAX_ROW=200 so the
// illegal row-length codes can be exercised.
module tb_multi_line_buffer;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int NL = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [AW-1:0]     row_length = '0;
    logic              fifo_reset = 1'b0;
    logic              shifting = 1'b0;
    logic [DW-1:0]     wr_data_i = '0;
    logic [NL*DW-1:0]  rd_a, rd_b;
    logic [NL-1:0]     lv_a, lv_b;
    logic              err_a, err_b;

    int                n_checks = 0;
    int                n_errors = 0;
    logic [DW-1:0]     hist [0:1023];
    int                n_sh = 0;
    int                cur_l = 1;

    always #5 clk = ~clk;

    multi_line_buffer dut_a (
        .clk          (clk),
        .rst          (rst),
        .row_length   (row_length),
        .fifo_reset   (fifo_reset),
        .shifting     (shifting),
        .wr_data_i    (wr_data_i),
        .rd_data_o    (rd_a),
        .line_valid_o (lv_a),
        .cfg_err_o    (err_a)
    );

    multi_line_buffer #(
        .DATA_W    (DW),
        .MAX_ROW   (200),
        .ADDR_W    (AW),
        .NUM_LINES (NL)
    ) dut_b (
        .clk          (clk),
        .rst          (rst),
        .row_length   (row_length),
        .fifo_reset   (fifo_reset),
        .shifting     (shifting),
        .wr_data_i    (wr_data_i),
        .rd_data_o    (rd_b),
        .line_valid_o (lv_b),
        .cfg_err_o    (err_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] tap_a(input int k);
        return rd_a[k*DW +: DW];
    endfunction

    task automatic clear(input int l);
        row_length = AW'(l);
        fifo_reset = 1'b1;
        @(posedge clk); #1;
        fifo_reset = 1'b0;
        n_sh  = 0;
        cur_l = (l == 0) ? 256 : l;
    endtask

    task automatic shift_px(input logic [DW-1:0] d);
        wr_data_i = d;
        shifting  = 1'b1;
        @(posedge clk); #1;
        shifting  = 1'b0;
        n_sh++;
        hist[n_sh] = d;
    endtask

    // Expected tap k after shift n: input of shift n-(k+1)*L, or 0 if unprimed.
    task automatic check_model(input string tag);
        for (int k = 0; k < NL; k++) begin
            int            lag;
            logic [DW-1:0] e;
            lag = (k + 1) * cur_l;
            e   = (n_sh > lag) ? hist[n_sh - lag] : '0;
            check($sformatf("%s_tap%0d_n%0d", tag, k, n_sh), 32'(tap_a(k)), 32'(e));
            check($sformatf("%s_vld%0d_n%0d", tag, k, n_sh), 32'(lv_a[k]), 32'(n_sh > lag));
        end
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_data", rd_a, 32'h0);
        check("rst_valid", 32'(lv_a), 32'h0);
        check("rst_err", 32'(err_a), 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;

        // Shifting before any fifo_reset is ignored
        shift_px(16'd55);
        check("pre_cfg_data", rd_a, 32'h0);
        check("pre_cfg_valid", 32'(lv_a), 32'h0);
        check("pre_cfg_err", 32'(err_a), 32'h1);

        // 1: L=10, inputs 21..70
        clear(10);
        check("t1_err", 32'(err_a), 32'h0);
        check("t1_clr_data", rd_a, 32'h0);
        for (int i = 1; i <= 50; i++) begin
            shift_px(DW'(20 + i));
            check_model("t1");
            if (i == 10) check("t1_n10_valid", 32'(lv_a), 32'h0);
            if (i == 11) begin
                check("t1_n11_tap0", 32'(tap_a(0)), 32'd21);
                check("t1_n11_valid", 32'(lv_a), 32'h1);
            end
            if (i == 21) begin
                check("t1_n21_tap1", 32'(tap_a(1)), 32'd21);
                check("t1_n21_valid", 32'(lv_a), 32'h3);
            end
            if (i == 50) begin
                check("t1_n50_tap0", 32'(tap_a(0)), 32'd60);
                check("t1_n50_tap1", 32'(tap_a(1)), 32'd50);
            end
        end

        // 2: pause for 7 cycles after 25 shifts
        clear(10);
        for (int i = 1; i <= 25; i++) shift_px(DW'(100 + i));
        for (int c = 0; c < 7; c++) begin
            wr_data_i = DW'(16'hBEEF);
            @(posedge clk); #1;
            check("t2_hold_tap0", 32'(tap_a(0)), 32'd115);
            check("t2_hold_tap1", 32'(tap_a(1)), 32'd105);
            check("t2_hold_valid", 32'(lv_a), 32'h3);
        end
        shift_px(DW'(126));
        check("t2_resume_tap0", 32'(tap_a(0)), 32'd116);
        check_model("t2");
        for (int i = 27; i <= 32; i++) begin
            shift_px(DW'(100 + i));
            check_model("t2");
        end

        // 3: clear coinciding with a shift, new L=4
        clear(10);
        for (int i = 1; i <= 30; i++) shift_px(DW'(200 + i));
        row_length = AW'(4);
        fifo_reset = 1'b1;
        shifting   = 1'b1;
        wr_data_i  = DW'(999);
        @(posedge clk); #1;
        fifo_reset = 1'b0;
        shifting   = 1'b0;
        n_sh  = 0;
        cur_l = 4;
        check("t3_clr_data", rd_a, 32'h0);
        check("t3_clr_valid", 32'(lv_a), 32'h0);
        for (int i = 1; i <= 12; i++) begin
            shift_px(DW'(300 + i));
            check_model("t3");
            if (i == 4) check("t3_n4_valid", 32'(lv_a), 32'h0);
            if (i == 5) begin
                check("t3_n5_tap0", 32'(tap_a(0)), 32'd301);
                check("t3_n5_valid", 32'(lv_a), 32'h1);
            end
            if (i == 9) begin
                check("t3_n9_tap1", 32'(tap_a(1)), 32'd301);
                check("t3_n9_valid", 32'(lv_a), 32'h3);
            end
        end

        // 4: L=256 via code 0, 600-pixel ramp across pointer wrap
        clear(0);
        check("t4_err_a", 32'(err_a), 32'h0);
        check("t4_err_b", 32'(err_b), 32'h1);
        for (int i = 1; i <= 600; i++) begin
            shift_px(DW'(i));
            check_model("t4");
        end
        check("t4_end_tap0", 32'(tap_a(0)), 32'd344);
        check("t4_end_tap1", 32'(tap_a(1)), 32'd88);
        check("t4_b_data", rd_b, 32'h0);
        check("t4_b_valid", 32'(lv_b), 32'h0);

        // 5: L=1 ramp
        clear(1);
        for (int i = 1; i <= 6; i++) begin
            shift_px(DW'(i));
            check_model("t5");
            if (i == 3) begin
                check("t5_n3_tap0", 32'(tap_a(0)), 32'd2);
                check("t5_n3_tap1", 32'(tap_a(1)), 32'd1);
            end
        end

        // 5b: MAX_ROW=200 instance, illegal and legal codes
        clear(250);
        check("t5b_250_err", 32'(err_b), 32'h1);
        shift_px(DW'(7));
        check("t5b_250_data", rd_b, 32'h0);
        clear(200);
        check("t5b_200_err", 32'(err_b), 32'h0);
        clear(5);
        check("t5b_5_err", 32'(err_b), 32'h0);

        // 6: asynchronous reset mid-stream
        clear(10);
        for (int i = 1; i <= 15; i++) shift_px(DW'(400 + i));
        check("t6_pre_tap0", 32'(tap_a(0)), 32'd405);
        #3;
        rst = 1'b0;
        #1;
        check("t6_async_data", rd_a, 32'h0);
        check("t6_async_valid", 32'(lv_a), 32'h0);
        check("t6_async_err", 32'(err_a), 32'h1);
        #2;
        rst = 1'b1;
        @(posedge clk); #1;
        for (int i = 1; i <= 3; i++) begin
            shift_px(DW'(500 + i));
            check("t6_ignored_data", rd_a, 32'h0);
            check("t6_ignored_err", 32'(err_a), 32'h1);
        end
        clear(10);
        check("t6_reload_err", 32'(err_a), 32'h0);
        for (int i = 1; i <= 11; i++) begin
            shift_px(DW'(600 + i));
            check_model("t6");
        end
        check("t6_n11_tap0", 32'(tap_a(0)), 32'd601);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multi_line_buffer.md
Name: multi_line_buffer

Overview:
- Parametrised successor to the single line FIFO.
- Chains NUM_LINES row-delay lines that share one circular pointer, so one input stream yields NUM_LINES taps. Tap k carries the pixel from (k+1) rows earlier.
- Feeds the KxK convolution window generator: K-1 row taps plus the live input form a window column.
- Adds per-tap valid flags, zero masking of unprimed taps, a latched row length and a configuration-error flag.

Parameters:
- DATA_W, 16, pixel/activation width in bits.
- MAX_ROW, 256, maximum row length; depth of each line RAM.
- ADDR_W, 8, width of row_length and pointer; must equal clog2(MAX_ROW).
- NUM_LINES, 2, number of chained row delays (K-1).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- row_length  in  ADDR_W  row length L. Legal range 1..MAX_ROW; the all-zero code means MAX_ROW only when MAX_ROW==2^ADDR_W, otherwise it is illegal.
- fifo_reset  in  1  synchronous clear of pointer and fill state; latches row_length.
- shifting  in  1  advance enable; one pixel is consumed per cycle while high.
- wr_data_i  in  DATA_W  input pixel.
- rd_data_o  out  NUM_LINES*DATA_W  tap k occupies bits [(k+1)*DATA_W-1 : k*DATA_W].
- line_valid_o  out  NUM_LINES  bit k high when tap k holds real data.
- cfg_err_o  out  1  latched row length is illegal.

Behaviour:
- Async reset (rst=0):
  - ptr=0, fill=0, row_len_q=0.
  - rd_data_o=0, line_valid_o=0.
  - cfg_err_o=1 until the first fifo_reset loads a legal L.
- fifo_reset=1 at a clock edge:
  - row_len_q<=row_length; ptr<=0; fill<=0.
  - rd_data_o<=0; line_valid_o<=0.
  - RAM contents are not cleared; stale data is hidden by masking.
  - fifo_reset wins over a simultaneous shifting=1; that shift is dropped.
- row_length is ignored while fifo_reset=0. Changing it mid-run has no effect.
- cfg_err_o=1 whenever row_len_q is illegal. While cfg_err_o=1, shifting is ignored and all outputs hold 0.
- Shift (shifting=1, fifo_reset=0, cfg_err_o=0), performed at the edge:
  - Line 0 reads mem0[ptr] and registers it into tap 0, then writes wr_data_i to mem0[ptr] (read-before-write).
  - Line k>0 reads memk[ptr] into tap k and writes the pre-edge value of mem(k-1)[ptr].
  - ptr <= (ptr==row_len_q-1) ? 0 : ptr+1.
  - fill <= min(fill+1, NUM_LINES*L).
- shifting=0: ptr, fill, RAM and outputs all hold.
- Latency: at the n-th shift after clear, tap k equals the input of shift n-(k+1)*L. This value is visible in the cycle after the edge.
- Valid flag:
  - line_valid_o[k] is registered with the tap.
  - It is 1 iff n > (k+1)*L, i.e. pre-edge fill >= (k+1)*L.
  - When line_valid_o[k]=0, tap k outputs 0.
- fill saturates, so there is no overflow on long frames. fill width is clog2(NUM_LINES*MAX_ROW+1).
- L=1: tap k is the input delayed by k+1 shifts. Pointer stays 0.
- L=MAX_ROW: ptr wraps MAX_ROW-1 -> 0 with no aliasing.
- Async reset mid-operation: immediate return to the reset state above. The next fifo_reset is required before shifting.

Decomposition:
- Package lb_pkg:
  - Defaults for DATA_W, MAX_ROW and NUM_LINES.
  - clog2 function.
  - Localparam FILL_W.
  - Helper returning the tap bit-slice base for index k.
- One sub-module, line_ram:
  - Single-port, read-before-write, DEPTH=MAX_ROW, DATA_W wide.
  - Combinational read, synchronous write.
  - Instantiated NUM_LINES times via generate.
- Top level holds the pointer, fill counter, row_len_q, tap registers and masking.

Test Plan:
1. Defaults, L=10. Sequence: rst low then high, fifo_reset=1 for one edge, then shift inputs 21..70. -> Taps 0 and valid 0 through shift 10. Shift 11 (input 31) -> tap0=21, valid[0]=1. Shift 21 (input 41) -> tap1=21, valid[1]=1. Shift 50 -> tap0=60, tap1=50.
2. L=10, shift 25 pixels, hold shifting=0 for 7 cycles, resume. -> Outputs frozen while paused; sequence continues without a gap. Tap0 after resume = input of shift 16.
3. L=10 run to shift 30, then fifo_reset=1 together with shifting=1 and row_length=4. -> Shift dropped, outputs and valid go to 0. Next shifts: tap0 valid from the 5th, tap1 from the 9th. Stale RAM never appears.
4. L=256 (max), 600 shifts of a ramp. -> tap0 = input-256, tap1 = input-512 across the pointer wrap. fill saturates at 512.
5. L=1 ramp 1,2,3... -> tap0 lags input by 1 shift and tap1 by 2. L=0 with MAX_ROW=200 -> cfg_err_o=1, shifting ignored, outputs 0.
6. Drive rst low mid-stream, asynchronously between clock edges. -> All outputs 0 immediately and cfg_err_o=1. After release, shifting has no effect until fifo_reset loads L.
